tl_axi_burst_bridge: RTL

Parametrised TileLink-UH device-side to AXI4 host-side bridge. It is the next-generation replacement for the fixed 32-bit single-beat TL-to-AXI conversion at the edge of the core. It converts multi-beat Get/PutFull/PutPartial into AXI INCR bursts, tracks outstanding reads and writes separately, and merges R/B back onto TL D without interleaving bursts. It removes the need for a separate TL width-down adapter in front of the memory port when the AXI data width equals the TL data width.

---
 rtl/tl_axi_burst_bridge.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/tl_axi_burst_bridge.sv
// TileLink-UH device to AXI4 host bridge with INCR bursts.
// Ports: clk/rst, host_a_* (TL A in), host_d_* (TL D out),
//        mem_aw/w/b/ar/r_* (AXI4 host side).
module tl_axi_burst_bridge #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int SourceWidth = 4,
    parameter int SizeWidth   = 3,
    parameter int MaxSize     = 6,
    parameter int Outstanding = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_a_valid,
    output logic                   host_a_ready,
    input  logic [2:0]             host_a_opcode,
    input  logic [2:0]             host_a_param,
    input  logic [SizeWidth-1:0]   host_a_size,
    input  logic [SourceWidth-1:0] host_a_source,
    input  logic [AddrWidth-1:0]   host_a_address,
    input  logic [DataWidth/8-1:0] host_a_mask,
    input  logic [DataWidth-1:0]   host_a_data,
    input  logic                   host_a_corrupt,
    output logic                   host_d_valid,
    input  logic                   host_d_ready,
    output logic [2:0]             host_d_opcode,
    output logic [1:0]             host_d_param,
    output logic [SizeWidth-1:0]   host_d_size,
    output logic [SourceWidth-1:0] host_d_source,
    output logic                   host_d_sink,
    output logic                   host_d_denied,
    output logic [DataWidth-1:0]   host_d_data,
    output logic                   host_d_corrupt,
    output logic                   mem_aw_valid,
    input  logic                   mem_aw_ready,
    output logic [SourceWidth-1:0] mem_aw_id,
    output logic [AddrWidth-1:0]   mem_aw_addr,
    output logic [7:0]             mem_aw_len,
    output logic [2:0]             mem_aw_size,
    output logic [1:0]             mem_aw_burst,
    output logic                   mem_w_valid,
    input  logic                   mem_w_ready,
    output logic [DataWidth-1:0]   mem_w_data,
    output logic [DataWidth/8-1:0] mem_w_strb,
    output logic                   mem_w_last,
    input  logic                   mem_b_valid,
    output logic                   mem_b_ready,
    input  logic [SourceWidth-1:0] mem_b_id,
    input  logic [1:0]             mem_b_resp,
    output logic                   mem_ar_valid,
    input  logic                   mem_ar_ready,
    output logic [SourceWidth-1:0] mem_ar_id,
    output logic [AddrWidth-1:0]   mem_ar_addr,
    output logic [7:0]             mem_ar_len,
    output logic [2:0]             mem_ar_size,
    output logic [1:0]             mem_ar_burst,
    input  logic                   mem_r_valid,
    output logic                   mem_r_ready,
    input  logic [SourceWidth-1:0] mem_r_id,
    input  logic [DataWidth-1:0]   mem_r_data,
    input  logic [1:0]             mem_r_resp,
    input  logic                   mem_r_last
);
    localparam int LB = $clog2(DataWidth / 8);
    localparam int CW = $clog2(Outstanding + 1);
    localparam int NS = 2 ** SourceWidth;

    typedef enum logic {IDLE, RBURST} d_state_e;

    logic                 is_get;
    logic                 is_put;
    logic [SizeWidth-1:0] sh;
    logic [7:0]           ax_len;
    logic [2:0]           ax_size;
    logic [CW-1:0]        rd_cnt;
    logic [CW-1:0]        wr_cnt;
    logic                 rd_ok;
    logic                 wr_ok;
    logic [7:0]           beat_cnt;
    logic                 first;
    logic                 w_last;
    logic                 aw_done;
    logic                 w_done;
    logic                 put_go;
    logic                 a_fire;
    logic                 ar_fire;
    logic                 aw_fire;
    logic                 w_fire;
    logic                 r_fire;
    logic                 b_fire;
    logic                 sel_b;
    logic                 sel_r;
    logic [SizeWidth-1:0] size_tab [NS];
    d_state_e             state;
    d_state_e             state_nx;
    logic                 a_unused;

    assign a_unused = ^{host_a_param, host_a_corrupt,
                        mem_r_resp[0], mem_b_resp[0]};

    assign is_get = (host_a_opcode == 3'd4);
    assign is_put = (host_a_opcode == 3'd0) || (host_a_opcode == 3'd1);

    // Burst length and beat size from the TL transfer size.
    always_comb begin
        sh      = '0;
        ax_len  = 8'd0;
        ax_size = 3'(host_a_size);
        if (host_a_size > SizeWidth'(LB)) begin
            sh      = host_a_size - SizeWidth'(LB);
            ax_len  = 8'((9'd1 << sh) - 9'd1);
            ax_size = 3'(LB);
        end
    end

    assign rd_ok  = rd_cnt < CW'(Outstanding);
    assign wr_ok  = wr_cnt < CW'(Outstanding);
    assign first  = (beat_cnt == 8'd0);
    assign w_last = (beat_cnt == ax_len);

    // Once either half of the first beat has gone out, the burst is
    // committed and must not be throttled by the write counter.
    assign put_go = host_a_valid & is_put &
                    (!first | wr_ok | aw_done | w_done);

    assign mem_aw_valid = put_go & first & !aw_done;
    assign mem_w_valid  = put_go & !(first & w_done);
    assign mem_ar_valid = host_a_valid & is_get & rd_ok;

    always_comb begin
        host_a_ready = 1'b0;
        if (is_get) begin
            host_a_ready = mem_ar_valid & mem_ar_ready;
        end else if (is_put) begin
            if (first)
                host_a_ready = put_go & (w_done | mem_w_ready) &
                               (aw_done | mem_aw_ready);
            else
                host_a_ready = put_go & mem_w_ready;
        end
    end

    assign mem_aw_id    = host_a_source;
    assign mem_aw_addr  = host_a_address;
    assign mem_aw_len   = ax_len;
    assign mem_aw_size  = ax_size;
    assign mem_aw_burst = 2'b01;
    assign mem_ar_id    = host_a_source;
    assign mem_ar_addr  = host_a_address;
    assign mem_ar_len   = ax_len;
    assign mem_ar_size  = ax_size;
    assign mem_ar_burst = 2'b01;
    assign mem_w_data   = host_a_data;
    assign mem_w_strb   = host_a_mask;
    assign mem_w_last   = w_last;

    assign a_fire  = host_a_valid & host_a_ready;
    assign ar_fire = mem_ar_valid & mem_ar_ready;
    assign aw_fire = mem_aw_valid & mem_aw_ready;
    assign w_fire  = mem_w_valid & mem_w_ready;
    assign r_fire  = mem_r_valid & mem_r_ready;
    assign b_fire  = mem_b_valid & mem_b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 8'd0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            for (int i = 0; i < NS; i++)
                size_tab[i] <= '0;
        end else begin
            if (a_fire & is_put)
                beat_cnt <= w_last ? 8'd0 : beat_cnt + 8'd1;
            if (a_fire & is_put & first)
                aw_done <= 1'b0;
            else if (aw_fire)
                aw_done <= 1'b1;
            // First W beat may complete while AW is still pending.
            if (a_fire & is_put & first)
                w_done <= 1'b0;
            else if (w_fire & first)
                w_done <= 1'b1;
            rd_cnt <= rd_cnt + CW'(ar_fire) - CW'(r_fire & mem_r_last);
            wr_cnt <= wr_cnt + CW'(aw_fire) - CW'(b_fire);
            if (ar_fire | aw_fire)
                size_tab[host_a_source] <= host_a_size;
        end
    end

    // D arbiter: B wins only between R bursts.
    assign sel_b = (state == IDLE) & mem_b_valid;
    assign sel_r = !sel_b & mem_r_valid;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (r_fire & !mem_r_last)
                    state_nx = RBURST;
            RBURST:
                if (r_fire & mem_r_last)
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    assign mem_b_ready    = host_d_ready & sel_b;
    assign mem_r_ready    = host_d_ready & sel_r;
    assign host_d_valid   = sel_b | sel_r;
    assign host_d_opcode  = sel_r ? 3'd1 : 3'd0;
    assign host_d_param   = 2'd0;
    assign host_d_sink    = 1'b0;
    assign host_d_source  = sel_r ? mem_r_id : mem_b_id;
    assign host_d_size    = sel_r ? size_tab[mem_r_id] : size_tab[mem_b_id];
    assign host_d_data    = sel_r ? mem_r_data : '0;
    assign host_d_denied  = sel_r ? mem_r_resp[1] : mem_b_resp[1];
    assign host_d_corrupt = sel_r & mem_r_resp[1];

    a_legal: assert property (@(posedge clk) disable iff (rst)
        host_a_valid |-> ((is_get | is_put) &&
                          (host_a_size <= SizeWidth'(MaxSize))));

endmodule
